// File: rtl/axi_gp_pkg.sv
// rtl/axi_gp_pkg.sv - shared constants and types for the AXI GP memory responder
//
// Purpose : burst encodings, response codes, beat size, FSM state types and
//           the WRAP length qualifier used by the address generator.
// Ports   : none (package).
// Config  : AXI_GP_WRAP_EN selects WRAP burst support in axi_gp_addr_gen.

package axi_gp_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BEAT_BYTES = 4;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // WRAP is only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_gp_mem_slave_if.sv
// rtl/axi_gp_mem_slave_if.sv - AXI4 subset bundle between the PS GP master and the responder
//
// Purpose : groups the AW/W/B/AR/R channel signals (32-bit data, ID_W-bit IDs).
// Modports: slave  - the memory responder (drives readies, B and R channels)
//           master - the requester (drives AW/W/AR channels and bready/rready)

interface axi_gp_mem_slave_if #(
  parameter int ID_W = 12
);

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_gp_addr_gen.sv
// rtl/axi_gp_addr_gen.sv - combinational next-beat address for one AXI burst
//
// Purpose : given the current beat address, burst type and len, produce the
//           address of the following beat and flag unsupported bursts.
// Ports   : addr      in  32  current beat byte address
//           burst     in  2   AXI burst type
//           len       in  8   AXI len (beats - 1)
//           next_addr out 32  address of the next beat
//           burst_err out 1   burst type/len not supported (whole burst errors)
// Config  : AXI_GP_WRAP_EN enables WRAP for len in {1,3,7,15}; otherwise WRAP
//           is treated like the reserved encoding.

module axi_gp_addr_gen
  import axi_gp_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  burst,
  input  logic [7:0]  len,
  output logic [31:0] next_addr,
  output logic        burst_err
);

`ifdef AXI_GP_WRAP_EN
  // Byte mask of the aligned wrap block: (len+1)*4 bytes.
  logic [31:0] wrap_mask;
  assign wrap_mask = ((32'(len) + 32'd1) << 2) - 32'd1;
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  always_comb begin
    next_addr = addr;
    burst_err = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = addr + 32'(BEAT_BYTES);
`ifdef AXI_GP_WRAP_EN
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_addr = (addr & ~wrap_mask) | ((addr + 32'(BEAT_BYTES)) & wrap_mask);
        end else begin
          burst_err = 1'b1;
        end
      end
`endif
      default:     burst_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_gp_mem_slave.sv
// rtl/axi_gp_mem_slave.sv - AXI4 GP-port responder backed by a word-addressed register memory
//
// Purpose : terminates PS GP master reads and writes into DEPTH 32-bit words at
//           BASE_ADDR. One write and one read burst may run concurrently.
// Ports   : clk   in  1  single clock
//           rst_n in  1  asynchronous active-low reset
//           bus   axi_gp_mem_slave_if.slave  AW/W/B/AR/R channels
// Config  : AXI_GP_WRAP_EN (in axi_gp_addr_gen) enables WRAP bursts.

module axi_gp_mem_slave
  import axi_gp_pkg::*;
#(
  parameter int          ID_W      = 12,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_gp_mem_slave_if.slave   bus
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  // Not reset: contents survive a mid-burst reset.
  logic [31:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < ADDR_LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- write channel ----------------
  wr_state_t       w_state;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_addr;
  logic [7:0]      w_len;
  logic [7:0]      w_cnt;
  logic [1:0]      w_burst;
  logic            w_err;
  logic            awready_q;
  logic            wready_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic [ID_W-1:0] bid_q;

  logic [31:0]     wg_next;
  logic            wg_err;
  logic            w_fire;
  logic            w_last_beat;
  logic            w_beat_ok;
  logic            w_beat_err;
  logic [IDX_W-1:0] w_idx;

  axi_gp_addr_gen u_wr_addr (
    .addr      (w_addr),
    .burst     (w_burst),
    .len       (w_len),
    .next_addr (wg_next),
    .burst_err (wg_err)
  );

  assign w_fire      = bus.wvalid && wready_q;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_ok   = !wg_err && in_range(w_addr);
  // wlast is only checked, never trusted: the counter decides the burst end.
  assign w_beat_err  = !w_beat_ok || (bus.wlast != w_last_beat);
  assign w_idx       = word_idx(w_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= '0;
      w_err     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (bus.awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id      <= bus.awid;
            w_addr    <= bus.awaddr;
            w_len     <= bus.awlen;
            w_burst   <= bus.awburst;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= wg_next;
            w_err  <= w_err | w_beat_err;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= w_id;
              bresp_q  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && w_beat_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;

  // ---------------- read channel ----------------
  rd_state_t       r_state;
  logic [31:0]     r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;
  logic [1:0]      r_burst;
  logic            arready_q;
  logic            rvalid_q;
  logic            rlast_q;
  logic [1:0]      rresp_q;
  logic [ID_W-1:0] rid_q;
  logic [31:0]     rdata_q;

  logic [31:0]     rg_addr;
  logic [1:0]      rg_burst;
  logic [7:0]      rg_len;
  logic [31:0]     rg_next;
  logic            rg_err;
  logic [31:0]     r_beat_addr;
  logic            r_beat_ok;
  logic [31:0]     r_beat_data;

  // While idle the generator qualifies the incoming AR request so the first
  // beat can be fetched on the handshake; afterwards it steps the burst.
  assign rg_addr  = (r_state == R_IDLE) ? bus.araddr  : r_addr;
  assign rg_burst = (r_state == R_IDLE) ? bus.arburst : r_burst;
  assign rg_len   = (r_state == R_IDLE) ? bus.arlen   : r_len;

  axi_gp_addr_gen u_rd_addr (
    .addr      (rg_addr),
    .burst     (rg_burst),
    .len       (rg_len),
    .next_addr (rg_next),
    .burst_err (rg_err)
  );

  // Address of the beat to be loaded into the R output register.
  assign r_beat_addr = (r_state == R_IDLE) ? bus.araddr : rg_next;
  assign r_beat_ok   = !rg_err && in_range(r_beat_addr);
  // Registered read: a same-edge write lands after this sample (pre-write value).
  assign r_beat_data = r_beat_ok ? mem[word_idx(r_beat_addr)] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (bus.arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= bus.arid;
            r_addr    <= bus.araddr;
            r_len     <= bus.arlen;
            r_burst   <= bus.arburst;
            r_cnt     <= '0;
            rdata_q   <= r_beat_data;
            rresp_q   <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_q   <= (bus.arlen == 8'd0);
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_addr  <= rg_next;
              rdata_q <= r_beat_data;
              rresp_q <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
              rlast_q <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_gp_mem_slave.sv
// tb/tb_axi_gp_mem_slave.sv - directed self-checking bench for axi_gp_mem_slave

module tb_axi_gp_mem_slave;
  import axi_gp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_gp_mem_slave_if #(.ID_W(12)) bus ();

  axi_gp_mem_slave #(.ID_W(12), .DEPTH(1024), .BASE_ADDR(32'h4000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_d [256];
  logic [1:0]  rd_r [256];
  logic        rd_l [256];
  int          rd_n;
  logic [11:0] rd_id;
  logic [3:0]  pat = 4'b1001;

  task automatic do_write(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int wlast_at, input int bhold,
                          output logic [1:0] resp, output logic [11:0] id_o);
    int t;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    chk("wready_lat", 32'(bus.wready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == wlast_at);
      t = 0;
      while (!bus.wready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) chk("w_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("bvalid_lat", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp; id_o = bus.bid;
    for (int i = 0; i < bhold; i++) begin
      chk("b_hold", {30'd0, bus.bvalid, bus.awready}, 32'b10);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    chk("aw_after_b", 32'(bus.awready), 32'd1);
  endtask

  task automatic do_read(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit stall);
    int t;
    bit held, done;
    logic [31:0] hd;
    logic [2:0]  hc;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    chk("rvalid_lat", 32'(bus.rvalid), 32'd1);
    rd_n = 0; held = 0; done = 0; hd = '0; hc = '0;
    t = 0;
    while (t < 2000 && !done) begin
      bus.rready = stall ? pat[t % 4] : 1'b1;
      if (bus.rvalid) begin
        if (held) begin
          chk("r_hold_data", bus.rdata, hd);
          chk("r_hold_ctl", {29'd0, bus.rresp, bus.rlast}, {29'd0, hc});
        end
        if (bus.rready) begin
          if (rd_n < 256) begin
            rd_d[rd_n] = bus.rdata; rd_r[rd_n] = bus.rresp; rd_l[rd_n] = bus.rlast;
          end
          rd_id = bus.rid;
          rd_n++;
          held = 0;
          done = bus.rlast;
        end else begin
          hd = bus.rdata; hc = {bus.rresp, bus.rlast};
          held = 1;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    bus.rready = 1'b0;
    chk("r_done", 32'(done), 32'd1);
    chk("r_end_rvalid", 32'(bus.rvalid), 32'd0);
  endtask

  logic [1:0]  resp;
  logic [11:0] bid_got;
  logic [31:0] exp_w [4];
  logic [1:0]  exp_r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_valids", {29'd0, bus.bvalid, bus.rvalid, bus.rlast}, 32'd0);
    chk("rst_resps", {28'd0, bus.bresp, bus.rresp}, 32'd0);
    chk("rst_ids", {8'd0, bus.bid, bus.rid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_up", 32'(bus.awready), 32'd1);
    chk("arready_up", 32'(bus.arready), 32'd1);

    // INCR write then read back
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 16; i++) ws[i] = 4'hF;
    do_write(12'h123, 32'h4000_0000, 8'd3, BURST_INCR, 3, 0, resp, bid_got);
    chk("t1_bresp", 32'(resp), 32'(RESP_OKAY));
    chk("t1_bid", 32'(bid_got), 32'h123);
    do_read(12'hABC, 32'h4000_0000, 8'd3, BURST_INCR, 0);
    chk("t1_rn", 32'(rd_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rdata", rd_d[i], 32'h11 * 32'(i + 1));
      chk("t1_rresp", 32'(rd_r[i]), 32'(RESP_OKAY));
      chk("t1_rlast", 32'(rd_l[i]), 32'(i == 3));
    end
    chk("t1_rid", 32'(rd_id), 32'hABC);

    // byte strobes
    wd[0] = 32'h0;
    do_write(12'h001, 32'h4000_0010, 8'd0, BURST_INCR, 0, 0, resp, bid_got);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(12'h002, 32'h4000_0010, 8'd0, BURST_INCR, 0, 0, resp, bid_got);
    ws[0] = 4'hF;
    chk("t2_bresp", 32'(resp), 32'(RESP_OKAY));
    do_read(12'h003, 32'h4000_0010, 8'd0, BURST_INCR, 0);
    chk("t2_rdata", rd_d[0], 32'h00BB_00DD);
    chk("t2_rlast", 32'(rd_l[0]), 32'd1);

    // read crossing the top of the window
    wd[0] = 32'hCAFE_F00D;
    do_write(12'h004, 32'h4000_0FFC, 8'd0, BURST_INCR, 0, 0, resp, bid_got);
    do_read(12'h005, 32'h4000_0FFC, 8'd1, BURST_INCR, 0);
    chk("t3_rn", 32'(rd_n), 32'd2);
    chk("t3_d0", rd_d[0], 32'hCAFE_F00D);
    chk("t3_r0", 32'(rd_r[0]), 32'(RESP_OKAY));
    chk("t3_d1", rd_d[1], 32'h0);
    chk("t3_r1", 32'(rd_r[1]), 32'(RESP_SLVERR));

    // rready stalls 1,0,0,1 over an 8-beat read
    for (int i = 0; i < 8; i++) wd[i] = 32'h1000 + 32'(i);
    do_write(12'h006, 32'h4000_0100, 8'd7, BURST_INCR, 7, 0, resp, bid_got);
    do_read(12'h007, 32'h4000_0100, 8'd7, BURST_INCR, 1);
    chk("t4_rn", 32'(rd_n), 32'd8);
    for (int i = 0; i < 8; i++) chk("t4_rdata", rd_d[i], 32'h1000 + 32'(i));
    chk("t4_rlast", {24'd0, rd_l[7], rd_l[6], rd_l[5], rd_l[4], rd_l[3], rd_l[2], rd_l[1], rd_l[0]}, 32'h80);

    // concurrent write (B held off 5 cycles) and read
    wd[0] = 32'h55; wd[1] = 32'h66; wd[2] = 32'h77; wd[3] = 32'h88;
    fork
      do_write(12'h0AA, 32'h4000_0200, 8'd3, BURST_INCR, 3, 5, resp, bid_got);
      do_read(12'h0BB, 32'h4000_0000, 8'd3, BURST_INCR, 0);
    join
    chk("t5_bresp", 32'(resp), 32'(RESP_OKAY));
    chk("t5_bid", 32'(bid_got), 32'h0AA);
    chk("t5_rn", 32'(rd_n), 32'd4);
    chk("t5_rd3", rd_d[3], 32'h44);
    do_read(12'h0CC, 32'h4000_0200, 8'd3, BURST_INCR, 0);
    chk("t5_wr0", rd_d[0], 32'h55);
    chk("t5_wr3", rd_d[3], 32'h88);

    // WRAP over the first four words
`ifdef AXI_GP_WRAP_EN
    exp_w[0] = 32'h33; exp_w[1] = 32'h44; exp_w[2] = 32'h11; exp_w[3] = 32'h22;
    exp_r = RESP_OKAY;
`else
    exp_w[0] = 32'h0; exp_w[1] = 32'h0; exp_w[2] = 32'h0; exp_w[3] = 32'h0;
    exp_r = RESP_SLVERR;
`endif
    do_read(12'h0DD, 32'h4000_0008, 8'd3, BURST_WRAP, 0);
    chk("t6_rn", 32'(rd_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_rdata", rd_d[i], exp_w[i]);
      chk("t6_rresp", 32'(rd_r[i]), 32'(exp_r));
    end
    chk("t6_rlast", {28'd0, rd_l[3], rd_l[2], rd_l[1], rd_l[0]}, 32'h8);

    // wlast misplaced: data lands, response is SLVERR
    wd[0] = 32'hA0A0_0001; wd[1] = 32'hA0A0_0002;
    do_write(12'h010, 32'h4000_0300, 8'd1, BURST_INCR, 0, 0, resp, bid_got);
    chk("t7_wlast_bresp", 32'(resp), 32'(RESP_SLVERR));
    do_read(12'h011, 32'h4000_0300, 8'd1, BURST_INCR, 0);
    chk("t7_wlast_d0", rd_d[0], 32'hA0A0_0001);
    chk("t7_wlast_d1", rd_d[1], 32'hA0A0_0002);

    // reserved burst: SLVERR, memory untouched
    wd[0] = 32'hFFFF_FFFF;
    do_write(12'h012, 32'h4000_0300, 8'd0, 2'b11, 0, 0, resp, bid_got);
    chk("t7_rsv_bresp", 32'(resp), 32'(RESP_SLVERR));
    do_read(12'h013, 32'h4000_0300, 8'd0, BURST_INCR, 0);
    chk("t7_rsv_keep", rd_d[0], 32'hA0A0_0001);

    // below the window
    do_write(12'h014, 32'h3FFF_FFFC, 8'd0, BURST_INCR, 0, 0, resp, bid_got);
    chk("t7_oor_bresp", 32'(resp), 32'(RESP_SLVERR));

    // FIXED write then FIXED read
    wd[0] = 32'hA1; wd[1] = 32'hB2; wd[2] = 32'hC3;
    do_write(12'h015, 32'h4000_0040, 8'd2, BURST_FIXED, 2, 0, resp, bid_got);
    chk("t8_bresp", 32'(resp), 32'(RESP_OKAY));
    do_read(12'h016, 32'h4000_0040, 8'd1, BURST_FIXED, 0);
    chk("t8_d0", rd_d[0], 32'hC3);
    chk("t8_d1", rd_d[1], 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
